// File: rtl/regfile_pkg.sv
// Shared sizes and requester identifiers for the register file read-port arbiter.
package regfile_pkg;

   localparam int DEF_WORD_LENGTH = 32;
   localparam int DEF_ADDR_WIDTH  = 5;
   localparam int NUM_REGS        = 32;

   localparam logic REQ_ID0 = 1'b0;
   localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; a requester whose grant is currently high is
// masked for that edge, and ties go to whoever did not win last.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] win,
   output logic [1:0] gnt
);

   logic       last_owner;
   logic [1:0] elig;

   // A held request is ignored during its own grant cycle.
   assign elig = req & ~gnt;

   always_comb begin
      win = 2'b00;
      case (elig)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = (last_owner == REQ_ID1) ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt        <= 2'b00;
         last_owner <= REQ_ID1;
      end else begin
         gnt <= win;
         if (|win) last_owner <= win[1];
      end
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file read port between two requesters: arbitrate and
// drive Selector on one edge, capture the (write-forwarded) word on the next.
module regfile_read_arbiter
   import regfile_pkg::*;
#(
   parameter int WORD_LENGTH = DEF_WORD_LENGTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   Req0,
   input  logic [ADDR_WIDTH-1:0]  Addr0,
   input  logic                   Req1,
   input  logic [ADDR_WIDTH-1:0]  Addr1,
   output logic                   Gnt0,
   output logic                   Gnt1,
   input  logic                   RegWrite,
   input  logic [ADDR_WIDTH-1:0]  WriteRegister,
   input  logic [WORD_LENGTH-1:0] WriteData,
   output logic [ADDR_WIDTH-1:0]  Selector,
   input  logic [WORD_LENGTH-1:0] Mux_Output,
   output logic [WORD_LENGTH-1:0] ReadData,
   output logic                   ReadValid,
   output logic                   ReadID
);

   // Handshake: ReqX is a level held with AddrX stable until a one-cycle GntX
   // pulse; the word returns one cycle after GntX as a one-cycle ReadValid
   // strobe with ReadID naming the owner. There is no back-pressure on ReadValid.

   logic [1:0] win;
   logic [1:0] gnt;
   logic       owner;
   logic       s1_valid;
   logic       fwd;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({Req1, Req0}),
      .win   (win),
      .gnt   (gnt)
   );

   assign Gnt0 = gnt[0];
   assign Gnt1 = gnt[1];

   // A write landing on the edge we capture would leave the mux showing the old word.
   assign fwd = RegWrite && (WriteRegister == Selector);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Selector  <= '0;
         owner     <= REQ_ID0;
         s1_valid  <= 1'b0;
         ReadValid <= 1'b0;
         ReadID    <= REQ_ID0;
         ReadData  <= '0;
      end else begin
         s1_valid <= |win;
         if (win[0]) begin
            Selector <= Addr0;
            owner    <= REQ_ID0;
         end else if (win[1]) begin
            Selector <= Addr1;
            owner    <= REQ_ID1;
         end

         ReadValid <= s1_valid;
         if (s1_valid) begin
            ReadID   <= owner;
            ReadData <= fwd ? WriteData : Mux_Output;
         end
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomized plus directed bench for regfile_read_arbiter with a register file
// model, a request-level reference model and an expected-response queue.
module tb_regfile_read_arbiter;
   import regfile_pkg::*;

   localparam int W  = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          Req0 = 1'b0, Req1 = 1'b0;
   logic [AW-1:0] Addr0 = '0, Addr1 = '0;
   logic          Gnt0, Gnt1;
   logic          RegWrite = 1'b0;
   logic [AW-1:0] WriteRegister = '0;
   logic [W-1:0]  WriteData = '0;
   logic [AW-1:0] Selector;
   logic [W-1:0]  Mux_Output;
   logic [W-1:0]  ReadData;
   logic          ReadValid;
   logic          ReadID;

   int n_checks = 0;
   int n_pass   = 0;
   logic mon_en = 1'b0;

   regfile_read_arbiter #(.WORD_LENGTH(W), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .Req0(Req0), .Addr0(Addr0), .Req1(Req1), .Addr1(Addr1),
      .Gnt0(Gnt0), .Gnt1(Gnt1),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .Selector(Selector), .Mux_Output(Mux_Output),
      .ReadData(ReadData), .ReadValid(ReadValid), .ReadID(ReadID)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- register file environment ----------------
   logic [W-1:0] regs [NUM_REGS];
   assign Mux_Output = regs[Selector];
   always @(posedge clk) if (RegWrite) regs[WriteRegister] <= WriteData;

   // ---------------- reference model ----------------
   logic          m_gnt0, m_gnt1, m_last;
   logic [AW-1:0] m_sel;
   logic          m_pend_valid, m_pend_id;
   logic [AW-1:0] m_pend_addr;
   logic [W:0]    exp_q[$];

   logic          e0, e1, w_any, w_id;
   logic [AW-1:0] w_addr;
   logic [W-1:0]  exp_word;

   always_comb begin
      e0       = Req0 && !m_gnt0;
      e1       = Req1 && !m_gnt1;
      w_any    = e0 || e1;
      w_id     = (e0 && e1) ? !m_last : e1;
      w_addr   = w_id ? Addr1 : Addr0;
      exp_word = (RegWrite && WriteRegister == m_pend_addr) ? WriteData : regs[m_pend_addr];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_gnt0       <= 1'b0;
         m_gnt1       <= 1'b0;
         m_last       <= 1'b1;
         m_sel        <= '0;
         m_pend_valid <= 1'b0;
         m_pend_id    <= 1'b0;
         m_pend_addr  <= '0;
         exp_q.delete();
      end else begin
         m_gnt0 <= w_any && !w_id;
         m_gnt1 <= w_any && w_id;
         if (w_any) begin
            m_last <= w_id;
            m_sel  <= w_addr;
         end
         if (m_pend_valid) exp_q.push_back({m_pend_id, exp_word});
         m_pend_valid <= w_any;
         m_pend_id    <= w_id;
         m_pend_addr  <= w_addr;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         logic [W:0] e;
         chk("gnt0", Gnt0, m_gnt0);
         chk("gnt1", Gnt1, m_gnt1);
         chk("selector", Selector, m_sel);
         chk("read_valid", ReadValid, exp_q.size() != 0);
         if (ReadValid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("read_id", ReadID, e[W]);
            chk("read_data", ReadData, e[W-1:0]);
         end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_gnt0", Gnt0, 0);
      chk("rst_gnt1", Gnt1, 0);
      chk("rst_valid", ReadValid, 0);
      chk("rst_id", ReadID, 0);
      chk("rst_data", ReadData, 0);
      chk("rst_sel", Selector, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
      @(negedge clk);
      RegWrite = 1'b1; WriteRegister = a; WriteData = d;
      @(negedge clk);
      RegWrite = 1'b0;
   endtask

   task automatic wait_gnt(input logic id);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ((id ? Gnt1 : Gnt0) === 1'b1) break;
      end
      chk("gnt_wait", id ? Gnt1 : Gnt0, 1);
   endtask

   task automatic fwd_case(input logic [AW-1:0] wr, input logic [W-1:0] exp_d);
      do_write(5'd12, 32'h1111_1111);
      Req1 = 1'b1; Addr1 = 5'd12;
      wait_gnt(1'b1);
      Req1 = 1'b0;
      RegWrite = 1'b1; WriteRegister = wr; WriteData = 32'h2222_2222;
      @(negedge clk);
      RegWrite = 1'b0;
      chk("fwd_valid", ReadValid, 1);
      chk("fwd_id", ReadID, 1);
      chk("fwd_data", ReadData, exp_d);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      mon_en = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) do_write(i[AW-1:0], $urandom);

      // single read
      do_write(5'd5, 32'hDEAD_BEEF);
      Req0 = 1'b1; Addr0 = 5'd5;
      wait_gnt(1'b0);
      chk("single_sel", Selector, 5);
      Req0 = 1'b0;
      @(negedge clk);
      chk("single_valid", ReadValid, 1);
      chk("single_id", ReadID, 0);
      chk("single_data", ReadData, 32'hDEAD_BEEF);

      // forwarding hit and miss
      fwd_case(5'd12, 32'h2222_2222);
      fwd_case(5'd13, 32'h1111_1111);

      // held request is masked in its grant cycle, then re-granted
      Req0 = 1'b1; Addr0 = 5'd4;
      wait_gnt(1'b0);
      @(negedge clk);
      chk("mask_gnt0_low", Gnt0, 0);
      @(negedge clk);
      chk("mask_gnt0_again", Gnt0, 1);
      Req0 = 1'b0;
      repeat (3) @(negedge clk);

      // both held from reset: strict alternation starting with requester 0
      Req0 = 1'b1; Addr0 = 5'd3; Req1 = 1'b1; Addr1 = 5'd9;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_gnt0", Gnt0, (i % 2) == 0);
         chk("rr_gnt1", Gnt1, (i % 2) == 1);
      end
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (3) @(negedge clk);

      // reset while a read is in flight
      Req0 = 1'b1; Addr0 = 5'd7;
      wait_gnt(1'b0);
      Req0 = 1'b0;
      do_reset();
      Req0 = 1'b1; Addr0 = 5'd2; Req1 = 1'b1; Addr1 = 5'd6;
      @(negedge clk);
      chk("post_rst_tie", {Gnt1, Gnt0}, 2'b01);
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (3) @(negedge clk);

      // requester 1 withdraws before ever being granted
      do_reset();
      Req0 = 1'b1; Addr0 = 5'd8; Req1 = 1'b1; Addr1 = 5'd10;
      @(negedge clk);
      Req0 = 1'b0; Req1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("withdraw_gnt1", Gnt1, 0);
         chk("withdraw_id", ReadValid && ReadID, 0);
      end

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (Req0 && Gnt0) begin
            Req0 = 1'($urandom_range(0, 1)); Addr0 = AW'($urandom);
         end else if (!Req0) begin
            Req0 = ($urandom_range(0, 2) != 0); Addr0 = AW'($urandom);
         end else if ($urandom_range(0, 9) == 0) begin
            Req0 = 1'b0;
         end else if ($urandom_range(0, 4) == 0) begin
            Addr0 = AW'($urandom);
         end
         if (Req1 && Gnt1) begin
            Req1 = 1'($urandom_range(0, 1)); Addr1 = AW'($urandom);
         end else if (!Req1) begin
            Req1 = ($urandom_range(0, 2) != 0); Addr1 = AW'($urandom);
         end else if ($urandom_range(0, 9) == 0) begin
            Req1 = 1'b0;
         end else if ($urandom_range(0, 4) == 0) begin
            Addr1 = AW'($urandom);
         end
         RegWrite      = 1'($urandom_range(0, 1));
         WriteRegister = ($urandom_range(0, 1) != 0) ? m_pend_addr : AW'($urandom);
         WriteData     = $urandom;
      end

      Req0 = 1'b0; Req1 = 1'b0; RegWrite = 1'b0;
      repeat (4) @(negedge clk);
      chk("drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
